uart_transmitter: RTL and testbench
===================================

# uart_transmitter

- Serial 8N1 UART transmitter with a small input FIFO. It is the transmit counterpart to the board's UART receive path, and it drives the `uart_tx` line that `top` produces toward a GPIO pin.
- Bytes arrive through a valid/ready handshake and are buffered. They are serialized LSB-first at a fixed baud rate derived from `clk_mhz`.

## Interface
Parameters:
- `clk_mhz`, 50: system clock frequency in MHz.
- `baud_rate`, 115200: serial bit rate.
- `fifo_depth`, 4: input FIFO entries; must be a power of two and at least 2.

Ports:
- `clk` input, 1: single system clock; all logic is on its rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `data` input, 8: byte to send.
- `valid` input, 1: `data` is offered this cycle.
- `ready` output, 1: FIFO can accept a byte (not full).
- `tx` output, 1: serial line; idle is high.
- `busy` output, 1: FIFO is non-empty, or a frame is in progress.

## Operation
- `bit_cycles` = (`clk_mhz` * 1_000_000) / `baud_rate`, using integer truncation. The default gives 434.
- The baud counter is wide enough for `bit_cycles` - 1. It restarts at 0 at the start of every bit.
- A transfer happens on a rising edge where `valid` and `ready` are both 1. The byte is written into the FIFO.
- While `ready` is 0, `valid` is ignored. No write occurs and no data is corrupted.
- The FIFO uses wrap-around read and write pointers with an occupancy count.
  - Full: count = `fifo_depth`. Empty: count = 0.
  - A push and a pop in the same cycle leave the count unchanged.
  - While full, a push cannot occur because `ready` is 0.
- State machine states: IDLE, START, DATA, PARITY (only when configured), STOP.
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop its head into the shift register, clear the bit index, and go to START.
  - START: `tx` = 0 for `bit_cycles`, then go to DATA.
  - DATA: `tx` = shift register bit 0, held for `bit_cycles`. Then shift right and increment the bit index. After bit 7, go to PARITY if configured, otherwise STOP.
  - PARITY: `tx` = parity bit, held for `bit_cycles`, then go to STOP.
  - STOP: `tx` = 1 for `bit_cycles`. On the last cycle:
    - If the FIFO is non-empty, pop and go directly to START. Frames run back-to-back with no extra idle cycle.
    - Otherwise go to IDLE.
- `tx` is registered and glitch-free.
- `ready` = !full, decoded from registered state.
- `busy` = (state != IDLE) || (count != 0).
- Reset values:
  - `tx` = 1, `ready` = 1, `busy` = 0.
  - FIFO is emptied; state is IDLE.
  - Baud counter and bit index are 0.
- A reset in the middle of a frame aborts it. `tx` is 1 from the edge after reset, and all queued bytes are discarded.

## Timing
- Edge E0 accepts a byte while the FIFO is empty and the state is IDLE.
  - At E1 the FSM pops the byte.
  - `tx` is 0 from E1 onward.
  - `busy` is 1 from E0 onward.
- Each bit occupies exactly `bit_cycles` clocks.
- One frame lasts 10 × `bit_cycles` (11 × with parity).
- With the FIFO kept non-empty, sustained throughput is exactly one frame per 10 (or 11) × `bit_cycles`.
- After the last stop bit with the FIFO empty, `busy` falls on the same edge that enters IDLE.
- `ready` drops on the edge that makes the FIFO full. It rises on the edge of the next pop.

## Configuration
- Macro: `UART_TRANSMITTER_PARITY_EN`.
- Defined:
  - The PARITY state is present. An even-parity bit (XOR of the 8 data bits) is sent between bit 7 and the stop bit.
  - The frame is 11 bits (8E1).
- Undefined:
  - No PARITY state and no parity logic.
  - The frame is 10 bits (8N1).

## Test plan
All scenarios use `clk_mhz` = 1 and `baud_rate` = 100000, so `bit_cycles` = 10.

- Single byte, no parity:
  - Stimulus: push 0x55 at E0.
  - Response: `tx` is low for cycles 1–10 after E0. It then carries 1,0,1,0,1,0,1,0 in 10-cycle bits, then stays high.
  - `busy` = 0 exactly 101 cycles after E0.
- FIFO fill:
  - Stimulus: while IDLE, push 0x01, 0x02, 0x03, 0x04, 0x05 on consecutive cycles with `valid` held high.
  - Response: 0x01 is popped at once. 0x02–0x05 fill the FIFO, and `ready` = 0 after the 5th push.
  - A 6th byte 0xFF held on `valid` is not accepted until the first pop.
  - The line carries 0x01–0x05 then 0xFF back-to-back, with no idle cycles between stop and start bits.
- Parity (macro defined):
  - Push 0x07: parity bit = 1, frame length 110 cycles.
  - Push 0x03: parity bit = 0.
- Reset mid-frame:
  - Stimulus: assert `rst` for one cycle during data bit 3 of 0xA5, with 2 more bytes queued.
  - Response: `tx` = 1, `ready` = 1, `busy` = 0 from the next edge. No further frames are sent.
- Idle holding:
  - With `valid` = 0 for 1000 cycles after reset, `tx` stays 1 and `busy` stays 0 throughout.

Source files
------------

// File: rtl/uart_transmitter.sv
// Serial UART transmitter (8N1) with a small power-of-two input FIFO.
// Define UART_TRANSMITTER_PARITY_EN to insert an even-parity bit (8E1 framing).
`timescale 1ns / 1ps

module uart_transmitter #(
    parameter int unsigned clk_mhz    = 50,
    parameter int unsigned baud_rate  = 115200,
    parameter int unsigned fifo_depth = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned bit_cycles = (clk_mhz * 1_000_000) / baud_rate;
    localparam int unsigned cnt_w      = (bit_cycles > 1) ? $clog2(bit_cycles) : 1;
    localparam int unsigned ptr_w      = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam int unsigned last_val   = bit_cycles - 1;
    localparam int unsigned depth_val  = fifo_depth;

    localparam logic [cnt_w-1:0] last_cnt = last_val[cnt_w-1:0];
    localparam logic [ptr_w:0]   full_cnt = depth_val[ptr_w:0];

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_TRANSMITTER_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [7:0]       mem_q [fifo_depth];
    logic [ptr_w-1:0] wr_ptr_q;
    logic [ptr_w-1:0] rd_ptr_q;
    logic [ptr_w:0]   count_q;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [7:0]       head;

    assign full  = (count_q == full_cnt);
    assign empty = (count_q == '0);
    assign ready = ~full;
    assign push  = valid & ready;
    assign head  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_w'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + {{ptr_w{1'b0}}, 1'b1};
            end else if (pop && !push) begin
                count_q <= count_q - {{ptr_w{1'b0}}, 1'b1};
            end
        end
    end

    // Storage needs no reset: occupancy is governed entirely by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data;
        end
    end

    // ------------------------------------------------------------------
    // Framing state machine
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [cnt_w-1:0] baud_q, baud_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             baud_done;
`ifdef UART_TRANSMITTER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign baud_done = (baud_q == last_cnt);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TRANSMITTER_PARITY_EN
        parity_d = parity_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (baud_done) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TRANSMITTER_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_TRANSMITTER_PARITY_EN
            StParity: begin
                if (baud_done) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (baud_done) begin
                    // Chain straight into the next start bit when more data is queued.
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StIdle) begin
            baud_d = baud_done ? '0 : baud_q + cnt_w'(1);
        end

        if (pop) begin
            shift_d = head;
            idx_d   = '0;
            baud_d  = '0;
`ifdef UART_TRANSMITTER_PARITY_EN
            parity_d = ^head;
`endif
        end
    end

    // Line level is derived from the next state so tx_q changes on the same edge as the state.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
`ifdef UART_TRANSMITTER_PARITY_EN
            StParity: tx_d = parity_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

`ifdef UART_TRANSMITTER_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end
`endif

    assign tx   = tx_q;
    assign busy = (state_q != StIdle) || !empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: random and directed byte streams compared
// cycle by cycle against a frame-level model of the serial line.
`timescale 1ns / 1ps

module tb_uart_transmitter;

    localparam int BC = 10;
`ifdef UART_TRANSMITTER_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FL = BC * FB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       tx;
    logic       busy;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes[$];
    int         push_edges[$];
    int         idx;
    logic       prev_ready;

    uart_transmitter #(
        .clk_mhz   (1),
        .baud_rate (100000),
        .fifo_depth(4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .data (data),
        .valid(valid),
        .ready(ready),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // k counts edges after E0, the edge that accepted exp_bytes[0]; frames run back to back.
    function automatic logic model_tx(int k);
        int s, f, p;
        logic [7:0] b;
        if (k < 1) return 1'b1;
        s = (k - 1) / BC;
        f = s / FB;
        p = s % FB;
        if (f >= exp_bytes.size()) return 1'b1;
        b = exp_bytes[f];
        if (p == 0) return 1'b0;
        if (p <= 8) return b[p-1];
`ifdef UART_TRANSMITTER_PARITY_EN
        if (p == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    function automatic logic model_busy(int k);
        return k <= FL * exp_bytes.size();
    endfunction

    // Occupancy = pushes so far minus pops so far; pops happen at each frame start.
    function automatic logic model_ready(int k);
        int cnt;
        cnt = 0;
        foreach (push_edges[i]) if (push_edges[i] <= k) cnt++;
        for (int j = 0; j < exp_bytes.size(); j++) if (1 + FL * j <= k) cnt--;
        return cnt < 4;
    endfunction

    task automatic start_frames();
        @(negedge clk);
        idx        = 0;
        data       = exp_bytes[0];
        valid      = 1'b1;
        prev_ready = 1'b1;
        @(posedge clk);
    endtask

    // Called at each negedge: hold valid until the byte has been taken.
    task automatic drive_step();
        if (valid && prev_ready) idx++;
        if (idx < exp_bytes.size()) begin
            data  = exp_bytes[idx];
            valid = 1'b1;
        end else begin
            valid = 1'b0;
        end
        prev_ready = ready;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b want 1", tx); end
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_idle();
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            checks += 2;
            if (tx !== 1'b1) begin errors++; $display("FAIL idle_tx k=%0d: got %b want 1", k, tx); end
            if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy k=%0d: got %b want 0", k, busy); end
        end
    endtask

    task automatic test_single_byte();
        exp_bytes = '{8'h55};
        start_frames();
        for (int k = 0; k <= FL + 20; k++) begin
            @(negedge clk);
            checks += 2;
            if (tx !== model_tx(k)) begin
                errors++; $display("FAIL single_tx k=%0d: got %b want %b", k, tx, model_tx(k));
            end
            if (busy !== model_busy(k)) begin
                errors++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, model_busy(k));
            end
            drive_step();
        end
    endtask

    task automatic test_fifo_fill();
        exp_bytes  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'hFF};
        push_edges = '{0, 1, 2, 3, 4, 2 + FL};
        start_frames();
        for (int k = 0; k <= FL * 6 + 20; k++) begin
            @(negedge clk);
            checks += 3;
            if (tx !== model_tx(k)) begin
                errors++; $display("FAIL fill_tx k=%0d: got %b want %b", k, tx, model_tx(k));
            end
            if (busy !== model_busy(k)) begin
                errors++; $display("FAIL fill_busy k=%0d: got %b want %b", k, busy, model_busy(k));
            end
            if (ready !== model_ready(k)) begin
                errors++; $display("FAIL fill_ready k=%0d: got %b want %b", k, ready, model_ready(k));
            end
            drive_step();
        end
        push_edges.delete();
    endtask

    task automatic test_random_bytes();
        repeat (4) begin
            int n;
            n = $urandom_range(1, 5);
            exp_bytes.delete();
            for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom));
            start_frames();
            for (int k = 0; k <= FL * n + 20; k++) begin
                @(negedge clk);
                checks += 2;
                if (tx !== model_tx(k)) begin
                    errors++; $display("FAIL random_tx k=%0d: got %b want %b", k, tx, model_tx(k));
                end
                if (busy !== model_busy(k)) begin
                    errors++;
                    $display("FAIL random_busy k=%0d: got %b want %b", k, busy, model_busy(k));
                end
                drive_step();
            end
        end
    endtask

`ifdef UART_TRANSMITTER_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        logic       pbit [2];
        vals = '{8'h07, 8'h03};
        pbit = '{1'b1, 1'b0};
        for (int t = 0; t < 2; t++) begin
            exp_bytes = '{vals[t]};
            start_frames();
            for (int k = 0; k <= FL + 20; k++) begin
                @(negedge clk);
                checks += 2;
                if (tx !== model_tx(k)) begin
                    errors++; $display("FAIL parity_tx k=%0d: got %b want %b", k, tx, model_tx(k));
                end
                if (busy !== model_busy(k)) begin
                    errors++;
                    $display("FAIL parity_busy k=%0d: got %b want %b", k, busy, model_busy(k));
                end
                if (k == 9 * BC + 5) begin
                    checks++;
                    if (tx !== pbit[t]) begin
                        errors++; $display("FAIL parity_bit: got %b want %b", tx, pbit[t]);
                    end
                end
                drive_step();
            end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        exp_bytes = '{8'hA5, 8'($urandom), 8'($urandom)};
        start_frames();
        for (int k = 0; k <= 44; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== model_tx(k)) begin
                errors++; $display("FAIL midrst_tx k=%0d: got %b want %b", k, tx, model_tx(k));
            end
            drive_step();
        end
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        valid = 1'b0;
        for (int k = 0; k < 3 * FL; k++) begin
            if (k > 0) @(negedge clk);
            checks += 3;
            if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx_after k=%0d: got %b want 1", k, tx); end
            if (ready !== 1'b1) begin
                errors++; $display("FAIL midrst_ready k=%0d: got %b want 1", k, ready);
            end
            if (busy !== 1'b0) begin
                errors++; $display("FAIL midrst_busy k=%0d: got %b want 0", k, busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single_byte();
        test_fifo_fill();
        test_random_bytes();
`ifdef UART_TRANSMITTER_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
